// File: rtl/gamma_loader_if.sv
// -----------------------------------------------------------------------------
// gamma_loader_if
//   Groups the host curve stream and the gamma RAM write bus of gamma_loader.
//
//   Host side (driven by the master):
//     load_start   single-cycle pulse, begins a host curve load
//     load_abort   single-cycle pulse, cancels a load in progress
//     load_valid   host byte valid
//     load_data    host byte, entries arrive in address order
//     gamma_req    user request to enable gamma correction
//   Loader side (driven by the slave, i.e. gamma_loader):
//     load_ready   loader accepts a byte this cycle
//     gamma_en     registered enable to the gamma datapath
//     gamma_wr     RAM write strobe
//     gamma_wr_addr RAM write address (10 bits)
//     gamma_value  RAM write data
//     busy         identity fill or host load in progress
//     curve_valid  RAM holds a complete curve
//     load_err     sticky abort flag
// -----------------------------------------------------------------------------
interface gamma_loader_if;
  logic       load_start;
  logic       load_abort;
  logic       load_valid;
  logic [7:0] load_data;
  logic       load_ready;
  logic       gamma_req;
  logic       gamma_en;
  logic       gamma_wr;
  logic [9:0] gamma_wr_addr;
  logic [7:0] gamma_value;
  logic       busy;
  logic       curve_valid;
  logic       load_err;

  modport master (
    output load_start, load_abort, load_valid, load_data, gamma_req,
    input  load_ready, gamma_en, gamma_wr, gamma_wr_addr, gamma_value,
           busy, curve_valid, load_err
  );

  modport slave (
    input  load_start, load_abort, load_valid, load_data, gamma_req,
    output load_ready, gamma_en, gamma_wr, gamma_wr_addr, gamma_value,
           busy, curve_valid, load_err
  );
endinterface

// File: rtl/gamma_loader.sv
// -----------------------------------------------------------------------------
// gamma_loader
//   Owns the write port of the gamma curve RAM (R bank 0-255, G bank 256-511,
//   B bank 512-767). After reset (and after an abort) it writes an identity
//   curve into every bank, then accepts complete host curves over a
//   valid/ready byte stream. gamma_en is held low whenever the RAM contents
//   are incomplete or being rewritten.
//
//   Parameters:
//     ENTRIES        curve length per load / identity fill (<= 1024)
//     AUTO_IDENTITY  1: identity fill after reset and after abort
//                    0: go straight to IDLE instead
//
//   Ports:
//     clk_sys   sole clock
//     reset     synchronous, active-high
//     bus       gamma_loader_if.slave: host stream + RAM write bus + status
// -----------------------------------------------------------------------------
module gamma_loader #(
  parameter int unsigned ENTRIES       = 768,
  parameter bit          AUTO_IDENTITY = 1'b1
) (
  input  logic           clk_sys,
  input  logic           reset,
  gamma_loader_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDENT = 2'd0,
    ST_IDLE  = 2'd1,
    ST_LOAD  = 2'd2
  } state_e;

  localparam logic [9:0] LAST_IDX    = 10'(ENTRIES - 32'd1);
  localparam state_e     RESET_STATE = AUTO_IDENTITY ? ST_IDENT : ST_IDLE;

  state_e     state_q,       state_d;
  logic [9:0] cnt_q,         cnt_d;
  logic       pending_q,     pending_d;
  logic       curve_valid_q, curve_valid_d;
  logic       load_err_q,    load_err_d;
  logic       wr_q,          wr_d;
  logic [9:0] wr_addr_q,     wr_addr_d;
  logic [7:0] wr_value_q,    wr_value_d;
  logic       gamma_en_q,    gamma_en_d;

  logic       load_ready_s;
  logic       busy_s;
  logic       handshake_s;
  logic       at_last_s;

  // Status decoded straight from state; forced low while reset is applied so
  // the host never sees ready/busy before the block is running.
  always_comb begin
    load_ready_s = 1'b0;
    busy_s       = 1'b0;
    if (reset) begin
      load_ready_s = 1'b0;
      busy_s       = 1'b0;
    end else begin
      load_ready_s = (state_q == ST_LOAD);
      busy_s       = (state_q == ST_LOAD) || (state_q == ST_IDENT);
    end
  end

  assign handshake_s = bus.load_valid & load_ready_s;
  assign at_last_s   = (cnt_q == LAST_IDX);

  // Next-state, counter, flag and write-port decode.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    pending_d     = pending_q;
    curve_valid_d = curve_valid_q;
    load_err_d    = load_err_q;
    wr_d          = 1'b0;
    wr_addr_d     = wr_addr_q;
    wr_value_d    = wr_value_q;

    case (state_q)
      ST_IDENT: begin
        // One identity entry per cycle; the low byte of the address is the
        // value, so all three banks receive the same ramp.
        wr_d       = 1'b1;
        wr_addr_d  = cnt_q;
        wr_value_d = cnt_q[7:0];
        if (at_last_s) begin
          cnt_d     = 10'd0;
          pending_d = 1'b0;
          if (pending_q || bus.load_start) begin
            // A start requested during the fill goes straight into LOAD so
            // curve_valid never pulses between fill and load.
            state_d    = ST_LOAD;
            load_err_d = 1'b0;
          end else begin
            state_d       = ST_IDLE;
            curve_valid_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 10'd1;
          if (bus.load_start) begin
            pending_d = 1'b1;
          end else begin
            pending_d = pending_q;
          end
        end
      end

      ST_IDLE: begin
        // Start beats abort here; a lone abort is ignored.
        if (bus.load_start) begin
          state_d       = ST_LOAD;
          cnt_d         = 10'd0;
          curve_valid_d = 1'b0;
          load_err_d    = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_LOAD: begin
        if (bus.load_abort) begin
          // Abort wins over a simultaneous start; any byte in this cycle is
          // dropped.
          load_err_d    = 1'b1;
          cnt_d         = 10'd0;
          curve_valid_d = 1'b0;
          pending_d     = 1'b0;
          state_d       = AUTO_IDENTITY ? ST_IDENT : ST_IDLE;
        end else if (bus.load_start) begin
          // Restart from entry 0; the byte handshaken now is discarded.
          cnt_d      = 10'd0;
          load_err_d = 1'b0;
        end else if (handshake_s) begin
          wr_d       = 1'b1;
          wr_addr_d  = cnt_q;
          wr_value_d = bus.load_data;
          if (at_last_s) begin
            cnt_d         = 10'd0;
            state_d       = ST_IDLE;
            curve_valid_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 10'd1;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end

      default: begin
        state_d       = RESET_STATE;
        cnt_d         = 10'd0;
        pending_d     = 1'b0;
        curve_valid_d = 1'b0;
      end
    endcase
  end

  // Enable only when a complete curve is resident and nothing is rewriting it.
  always_comb begin
    gamma_en_d = bus.gamma_req & curve_valid_q & (state_q == ST_IDLE);
  end

  // State, counter, flags and the registered RAM write port.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q       <= RESET_STATE;
      cnt_q         <= 10'd0;
      pending_q     <= 1'b0;
      curve_valid_q <= 1'b0;
      load_err_q    <= 1'b0;
      wr_q          <= 1'b0;
      wr_addr_q     <= 10'd0;
      wr_value_q    <= 8'd0;
      gamma_en_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      pending_q     <= pending_d;
      curve_valid_q <= curve_valid_d;
      load_err_q    <= load_err_d;
      wr_q          <= wr_d;
      wr_addr_q     <= wr_addr_d;
      wr_value_q    <= wr_value_d;
      gamma_en_q    <= gamma_en_d;
    end
  end

  assign bus.load_ready    = load_ready_s;
  assign bus.busy          = busy_s;
  assign bus.gamma_en      = gamma_en_q;
  assign bus.gamma_wr      = wr_q;
  assign bus.gamma_wr_addr = wr_addr_q;
  assign bus.gamma_value   = wr_value_q;
  assign bus.curve_valid   = curve_valid_q;
  assign bus.load_err      = load_err_q;

endmodule

// File: tb/tb_gamma_loader.sv
// Self-checking bench for gamma_loader: a table of host-load scenarios plus
// hand-written sequences for abort, restart, pending start and reset corners.
// Expected RAM writes are built by the bench from the stimulus it drives.
module tb_gamma_loader;
  localparam int N = 768;

  logic clk_sys = 1'b0;
  logic reset;
  always #5 clk_sys = ~clk_sys;

  gamma_loader_if bus();

  gamma_loader #(.ENTRIES(N), .AUTO_IDENTITY(1'b1)) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .bus     (bus)
  );

  typedef struct {
    int addr;
    int value;
    int cyc;
  } wr_t;

  typedef struct {
    int mode;     // 0 back-to-back, 1 alternate valid, 2 random gaps
    int pat;      // 0 inverse ramp, 1 random, 2 ramp xor 0x5A
    bit req;      // gamma_req during the row
    bit exp_en;   // expected gamma_en after completion
    bit exp_cv;   // expected curve_valid after completion
    bit exp_err;  // expected load_err after completion
  } row_t;

  wr_t  got_q[$];
  wr_t  exp_q[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  int   cv_rise_cyc = 0, cv_rise_cnt = 0;
  int   en_rise_cyc = 0, en_fall_cyc = 0, en_rise_cnt = 0;
  logic cv_prev = 1'b0, en_prev = 1'b0;
  int   load_idx = 0;
  int   ready_low = 0;

  always @(posedge clk_sys) cyc <= cyc + 1;

  // Observe the write port and the status edges away from the active edge.
  always @(negedge clk_sys) begin
    if (bus.gamma_wr === 1'b1)
      got_q.push_back('{int'(bus.gamma_wr_addr), int'(bus.gamma_value), cyc});
    if (bus.curve_valid === 1'b1 && cv_prev !== 1'b1) begin
      cv_rise_cyc <= cyc;
      cv_rise_cnt <= cv_rise_cnt + 1;
    end
    if (bus.gamma_en === 1'b1 && en_prev !== 1'b1) begin
      en_rise_cyc <= cyc;
      en_rise_cnt <= en_rise_cnt + 1;
    end
    if (bus.gamma_en !== 1'b1 && en_prev === 1'b1)
      en_fall_cyc <= cyc;
    cv_prev <= bus.curve_valid;
    en_prev <= bus.gamma_en;
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic clear_logs();
    got_q.delete();
    exp_q.delete();
    load_idx  = 0;
    ready_low = 0;
  endtask

  function automatic int pat_byte(input int pat, input int n);
    case (pat)
      0:       return 255 - (n & 255);
      1:       return int'($urandom_range(0, 255));
      2:       return (n ^ 90) & 255;
      default: return 0;
    endcase
  endfunction

  // Present n bytes; every presented byte must be accepted and written to
  // the next sequential address one cycle later.
  task automatic drive_bytes(input int n, input int mode, input int pat);
    int d;
    int gap;
    for (int i = 0; i < n; i++) begin
      d = pat_byte(pat, load_idx);
      if (mode == 0) gap = 0;
      else if (mode == 1) gap = 1;
      else gap = int'($urandom_range(0, 3));
      if (bus.load_ready !== 1'b1) ready_low++;
      bus.load_valid = 1'b1;
      bus.load_data  = 8'(d);
      exp_q.push_back('{load_idx, d, cyc + 1});
      load_idx++;
      tick();
      bus.load_valid = 1'b0;
      if (gap > 0) tick(gap);
    end
  endtask

  task automatic push_identity(input int first_cyc);
    for (int n = 0; n < N; n++) exp_q.push_back('{n, n & 255, first_cyc + n});
  endtask

  task automatic compare_writes(input string name);
    int k;
    int lim;
    string nm;
    k   = 0;
    lim = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    while (k < lim && got_q[k].addr == exp_q[k].addr &&
           got_q[k].value == exp_q[k].value && got_q[k].cyc == exp_q[k].cyc) k++;
    check({name, " write count"}, got_q.size(), exp_q.size());
    if (k < lim)
      nm = $sformatf("%s write seq (idx %0d got a=%0d v=%0d c=%0d exp a=%0d v=%0d c=%0d)",
                     name, k, got_q[k].addr, got_q[k].value, got_q[k].cyc,
                     exp_q[k].addr, exp_q[k].value, exp_q[k].cyc);
    else
      nm = {name, " write seq"};
    check(nm, k, lim);
  endtask

  task automatic wait_cv(input int budget);
    int t;
    t = 0;
    while (!(bus.curve_valid === 1'b1 && bus.busy === 1'b0) && t < budget) begin
      tick();
      t++;
    end
    check("wait curve_valid within budget", (t < budget), 1);
  endtask

  task automatic do_reset(output int r);
    reset          = 1'b1;
    bus.load_start = 1'b0;
    bus.load_abort = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_data  = 8'd0;
    tick(3);
    check("reset gamma_wr",    bus.gamma_wr,    0);
    check("reset gamma_en",    bus.gamma_en,    0);
    check("reset curve_valid", bus.curve_valid, 0);
    check("reset load_err",    bus.load_err,    0);
    check("reset load_ready",  bus.load_ready,  0);
    check("reset busy",        bus.busy,        0);
    clear_logs();
    reset = 1'b0;
    r = cyc;
  endtask

  task automatic pulse_start();
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
  endtask

  row_t rows[5];

  initial begin
    int r, s, a, c, er0, cvc0;
    rows[0] = '{0, 0, 1'b1, 1'b1, 1'b1, 1'b0};
    rows[1] = '{1, 2, 1'b1, 1'b1, 1'b1, 1'b0};
    rows[2] = '{2, 1, 1'b0, 1'b0, 1'b1, 1'b0};
    rows[3] = '{2, 1, 1'b1, 1'b1, 1'b1, 1'b0};
    rows[4] = '{0, 1, 1'b1, 1'b1, 1'b1, 1'b0};

    bus.gamma_req = 1'b1;

    // Reset and identity fill.
    do_reset(r);
    push_identity(r + 1);
    wait_cv(N + 50);
    tick(2);
    compare_writes("ident");
    check("ident curve_valid rise", cv_rise_cyc, r + N);
    check("ident gamma_en rise",    en_rise_cyc, r + N + 1);
    check("ident gamma_en",         bus.gamma_en, 1);
    check("ident load_err",         bus.load_err, 0);

    // Table-driven full host loads.
    foreach (rows[i]) begin
      bus.gamma_req = rows[i].req;
      tick(2);
      clear_logs();
      er0 = en_rise_cnt;
      s = cyc;
      pulse_start();
      drive_bytes(N, rows[i].mode, rows[i].pat);
      tick(3);
      compare_writes($sformatf("row%0d", i));
      check($sformatf("row%0d ready during load", i), ready_low, 0);
      check($sformatf("row%0d curve_valid rise", i), cv_rise_cyc, exp_q[$].cyc);
      check($sformatf("row%0d curve_valid", i), bus.curve_valid, rows[i].exp_cv);
      check($sformatf("row%0d load_err", i),    bus.load_err,    rows[i].exp_err);
      check($sformatf("row%0d gamma_en", i),    bus.gamma_en,    rows[i].exp_en);
      check($sformatf("row%0d load_ready after", i), bus.load_ready, 0);
      check($sformatf("row%0d busy after", i),  bus.busy, 0);
      check($sformatf("row%0d gamma_en rises", i), en_rise_cnt - er0, rows[i].req ? 1 : 0);
      if (rows[i].req) begin
        check($sformatf("row%0d gamma_en fall", i), en_fall_cyc, s + 2);
        check($sformatf("row%0d gamma_en rise", i), en_rise_cyc, cv_rise_cyc + 1);
      end
    end

    // Abort at entry 300 -> sticky error and fresh identity fill.
    bus.gamma_req = 1'b1;
    clear_logs();
    pulse_start();
    drive_bytes(300, 0, 1);
    a = cyc;
    bus.load_abort = 1'b1;
    bus.load_valid = 1'b1;
    bus.load_data  = 8'h33;
    tick();
    bus.load_abort = 1'b0;
    bus.load_valid = 1'b0;
    check("abort load_err",    bus.load_err, 1);
    check("abort busy",        bus.busy, 1);
    check("abort curve_valid", bus.curve_valid, 0);
    push_identity(a + 2);
    wait_cv(N + 50);
    tick(2);
    compare_writes("abort300");
    check("abort curve_valid rise", cv_rise_cyc, a + 1 + N);
    check("abort load_err sticky",  bus.load_err, 1);

    // Reset mid-load, then start requested during the identity fill.
    clear_logs();
    pulse_start();
    drive_bytes(50, 0, 1);
    do_reset(r);
    push_identity(r + 1);
    cvc0 = cv_rise_cnt;
    while (cyc < r + 100) tick();
    pulse_start();
    while (cyc < r + 200) tick();
    bus.load_abort = 1'b1;
    tick();
    bus.load_abort = 1'b0;
    while (cyc < r + N) tick();
    check("pending load_ready", bus.load_ready, 1);
    check("pending curve_valid", bus.curve_valid, 0);
    drive_bytes(N, 2, 1);
    tick(3);
    compare_writes("pending");
    check("pending curve_valid rises", cv_rise_cnt - cvc0, 1);
    check("pending load_err", bus.load_err, 0);

    // Restart at entry 500; the byte in the restart cycle is dropped.
    clear_logs();
    pulse_start();
    drive_bytes(500, 0, 0);
    c = cyc;
    bus.load_start = 1'b1;
    bus.load_valid = 1'b1;
    bus.load_data  = 8'h77;
    tick();
    bus.load_start = 1'b0;
    bus.load_valid = 1'b0;
    load_idx = 0;
    drive_bytes(N, 1, 1);
    tick(3);
    compare_writes("restart500");
    check("restart first write cycle", exp_q[500].cyc, c + 2);
    check("restart curve_valid rise", cv_rise_cyc, exp_q[$].cyc);
    check("restart load_err", bus.load_err, 0);

    // Abort and start together in LOAD: abort wins.
    clear_logs();
    pulse_start();
    drive_bytes(10, 0, 2);
    a = cyc;
    bus.load_abort = 1'b1;
    bus.load_start = 1'b1;
    tick();
    bus.load_abort = 1'b0;
    bus.load_start = 1'b0;
    check("abort+start load_err", bus.load_err, 1);
    check("abort+start busy", bus.busy, 1);
    push_identity(a + 2);
    wait_cv(N + 50);
    tick(2);
    compare_writes("abort_start");
    check("abort+start curve_valid rise", cv_rise_cyc, a + 1 + N);

    // IDLE: lone abort ignored; abort with start -> start wins.
    bus.load_abort = 1'b1;
    tick();
    bus.load_abort = 1'b0;
    check("idle abort load_err", bus.load_err, 1);
    check("idle abort busy", bus.busy, 0);
    bus.load_abort = 1'b1;
    bus.load_start = 1'b1;
    tick();
    bus.load_abort = 1'b0;
    bus.load_start = 1'b0;
    check("idle abort+start load_err", bus.load_err, 0);
    check("idle abort+start load_ready", bus.load_ready, 1);
    clear_logs();
    drive_bytes(N, 2, 1);
    tick(3);
    compare_writes("idle_start");
    check("idle_start curve_valid", bus.curve_valid, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d, expected completion", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/gamma_loader.md
# gamma_loader

Sequencer that owns the write port of the 768-entry gamma curve RAM: three 256-byte banks, R at 0–255, G at 256–511, B at 512–767. It sits in the `clk_sys` domain between the host byte stream and the gamma bus signals `gamma_en`, `gamma_wr`, `gamma_wr_addr` and `gamma_value`. After reset it fills the RAM with an identity curve, then accepts complete host curves over a valid/ready stream. It holds `gamma_en` low whenever the RAM contents are incomplete or being rewritten.

## Interface
Parameters:
- ENTRIES, 768: curve length written per load or identity fill; must be ≤1024.
- AUTO_IDENTITY, 1: when 1, an identity fill runs after reset and after abort; when 0, the block goes straight to IDLE.

Ports:
- clk_sys  in  1  sole clock.
- reset  in  1  synchronous, active-high.
- load_start  in  1  single-cycle pulse; begins a host curve load.
- load_abort  in  1  single-cycle pulse; cancels a load in progress.
- load_valid  in  1  host byte valid.
- load_data  in  8  host byte; entries arrive in address order 0..ENTRIES-1.
- load_ready  out  1  block accepts a byte this cycle.
- gamma_req  in  1  user request to enable gamma correction.
- gamma_en  out  1  registered enable to the gamma datapath.
- gamma_wr  out  1  RAM write strobe.
- gamma_wr_addr  out  10  RAM write address.
- gamma_value  out  8  RAM write data.
- busy  out  1  high in IDENT or LOAD.
- curve_valid  out  1  RAM holds a complete curve.
- load_err  out  1  sticky; set by abort; cleared by the next load_start.

## Operation
- States: IDENT, IDLE, LOAD. 10-bit counter `cnt`.
- **IDENT**
  - Each cycle writes `gamma_wr_addr=cnt`, `gamma_value=cnt[7:0]`, so every bank gets the identity curve.
  - After the write at `cnt=ENTRIES-1`: go to IDLE, `curve_valid<=1`.
- **IDLE**
  - No writes.
  - `load_start` → LOAD, `cnt<=0`, `curve_valid<=0`, `load_err<=0`.
- **LOAD**
  - `load_ready=1` throughout.
  - Each handshake (`load_valid & load_ready`) writes `load_data` at `cnt`, then `cnt++`.
  - The handshake at `cnt=ENTRIES-1` → IDLE, `curve_valid<=1`.
  - `load_valid` low: no write, counter holds.
- `gamma_en <= gamma_req & curve_valid & (state==IDLE)`. Updated every cycle.
- **Boundary rules**
  - `load_start` during IDENT sets `pending`. When IDENT completes, the block enters LOAD directly; `curve_valid` never rises in between.
  - `load_start` during LOAD restarts: `cnt<=0`. A byte handshaken in the same cycle is discarded.
  - `load_abort` during LOAD: `load_err<=1`, `cnt<=0`, then IDENT (AUTO_IDENTITY=1) or IDLE with `curve_valid=0` (AUTO_IDENTITY=0).
  - `load_abort` in IDLE or IDENT is ignored.
  - `load_abort` and `load_start` in the same cycle during LOAD: abort wins.
  - `load_abort` and `load_start` in the same cycle in IDLE: start wins.
  - Reset mid-operation discards all progress; RAM contents are not cleared.
  - The counter never exceeds ENTRIES-1 and never wraps past it.

## Timing
- Reset values:
  - State IDENT if AUTO_IDENTITY, else IDLE.
  - `cnt=0`, `pending=0`.
  - All outputs 0, including `gamma_en`, `curve_valid`, `load_err` and `gamma_wr`.
  - `load_ready=0`. `busy=0` during reset.
- Write port is registered: `gamma_wr`, `gamma_wr_addr` and `gamma_value` update one cycle after the handshake or IDENT step. `gamma_wr` is high for exactly one cycle per entry.
- IDENT occupies ENTRIES cycles. The first write appears on the cycle after reset deasserts.
- `load_ready` and `busy` are decoded combinationally from state. `load_ready` deasserts the cycle after the final handshake.
- A full back-to-back load takes ENTRIES cycles from the first handshake. The last `gamma_wr` pulse and `curve_valid` rise occur on the same clock edge.
- `gamma_en` rises 1 cycle after `curve_valid` rises, provided `gamma_req=1`. It falls 1 cycle after LOAD is entered.
- Throughput: one entry per cycle; no internal stalls.

## Test plan
- **Reset, AUTO_IDENTITY=1, `gamma_req=1`:** 768 writes with `addr=n`, `value=n&255`. `curve_valid=1` after write 767. `gamma_en=1` one cycle later.
- **Full load, `load_data=255-(n&255)`, valid every cycle:** 768 writes with matching values. `gamma_en` is low throughout the load and returns high 1 cycle after completion. `load_err=0`.
- **Throttled load, `load_valid` toggled 1/0:** 768 writes in about 1536 cycles. Addresses are strictly sequential with no duplicates.
- **Abort at entry 300:** `load_err=1`. A fresh identity fill restarts at address 0. `curve_valid=1` after 768 more writes.
- **`load_start` at IDENT cycle 100:** IDENT completes its 768 writes. LOAD follows directly and `curve_valid` never pulses.
- **Restart and simultaneous events:** `load_start` reissued at LOAD entry 500 → next write goes to address 0. Abort and start together in LOAD → abort behaviour.
